// File: rtl/joypad_debounce_bank.sv
// Debounces a bank of raw joypad buttons sampled on a shared strobe.
// Ports: clock, reset (sync, active-high), inButtons (raw pins),
//   outPressed (debounced level), outPressed_tick / outReleased_tick
//   (one-cycle edges), outRepeat_tick (press plus auto-repeat),
//   outAnyPressed (OR of all levels, same cycle as outPressed).
module joypad_debounce_bank #(
  parameter int NUM_BUTTONS   = 12,
  parameter int SAMPLE_DIV    = 500000,
  parameter int HISTORY_DEPTH = 16,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_RATE   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] inButtons,
  output logic [NUM_BUTTONS-1:0] outPressed,
  output logic [NUM_BUTTONS-1:0] outPressed_tick,
  output logic [NUM_BUTTONS-1:0] outReleased_tick,
  output logic [NUM_BUTTONS-1:0] outRepeat_tick,
  output logic                   outAnyPressed
);

  localparam int TimerW = $clog2(SAMPLE_DIV);
  localparam logic [TimerW-1:0] TimerLoad =
    TimerW'(SAMPLE_DIV - 1);

  logic [TimerW-1:0] timer;
  logic              strobe;

  assign strobe = (timer == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= TimerLoad;
    end else if (strobe) begin
      timer <= TimerLoad;
    end else begin
      timer <= timer - TimerW'(1);
    end
  end

  logic [NUM_BUTTONS-1:0] syncA;
  logic [NUM_BUTTONS-1:0] syncB;
  logic [NUM_BUTTONS-1:0] level;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= inButtons;
      syncB <= syncA;
    end
  end

  assign level = (ACTIVE_LOW != 0) ? ~syncB : syncB;

  logic [HISTORY_DEPTH-1:0] history [NUM_BUTTONS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) begin
        history[i] <= '0;
      end else if (strobe) begin
        history[i] <= {history[i][HISTORY_DEPTH-2:0], level[i]};
      end
    end
  end

  logic [NUM_BUTTONS-1:0] pressedNext;
  logic [NUM_BUTTONS-1:0] pressedPrev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] fall;

  // Only a unanimous history moves the level; mixed patterns hold it.
  always_comb begin
    pressedNext = outPressed;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      unique case (1'b1)
        (&history[i]):  pressedNext[i] = 1'b1;
        (~|history[i]): pressedNext[i] = 1'b0;
        default:        pressedNext[i] = outPressed[i];
      endcase
    end
  end

  assign rise = outPressed & ~pressedPrev;
  assign fall = ~outPressed & pressedPrev;

  always_ff @(posedge clock) begin
    if (reset) begin
      outPressed       <= '0;
      outAnyPressed    <= 1'b0;
      pressedPrev      <= '0;
      outPressed_tick  <= '0;
      outReleased_tick <= '0;
    end else begin
      outPressed       <= pressedNext;
      outAnyPressed    <= |pressedNext;
      pressedPrev      <= outPressed;
      outPressed_tick  <= rise;
      outReleased_tick <= fall;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : genRepeat
      localparam int RcMax =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int RcW = $clog2(RcMax + 1);
      localparam logic [RcW-1:0] DelayLast = RcW'(REPEAT_DELAY - 1);
      localparam logic [RcW-1:0] RateLast  = RcW'(REPEAT_RATE - 1);

      localparam logic [1:0] StIdle   = 2'd0;
      localparam logic [1:0] StDelay  = 2'd1;
      localparam logic [1:0] StRepeat = 2'd2;

      logic [1:0]             state     [NUM_BUTTONS];
      logic [1:0]             stateNext [NUM_BUTTONS];
      logic [RcW-1:0]         rc        [NUM_BUTTONS];
      logic [RcW-1:0]         rcNext    [NUM_BUTTONS];
      logic [NUM_BUTTONS-1:0] autoNext;

      // The counter is compared against limit-1 so the strobe that
      // brings it to the limit fires the tick and clears it.
      always_comb begin
        autoNext = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
          stateNext[i] = state[i];
          rcNext[i]    = rc[i];
          if (!outPressed[i]) begin
            stateNext[i] = StIdle;
            rcNext[i]    = '0;
          end else begin
            unique case (state[i])
              StIdle: begin
                if (rise[i]) begin
                  stateNext[i] = StDelay;
                  rcNext[i]    = '0;
                end
              end
              StDelay: begin
                if (strobe) begin
                  if (rc[i] == DelayLast) begin
                    autoNext[i]  = 1'b1;
                    rcNext[i]    = '0;
                    stateNext[i] = StRepeat;
                  end else begin
                    rcNext[i] = rc[i] + RcW'(1);
                  end
                end
              end
              StRepeat: begin
                if (strobe) begin
                  if (rc[i] == RateLast) begin
                    autoNext[i] = 1'b1;
                    rcNext[i]   = '0;
                  end else begin
                    rcNext[i] = rc[i] + RcW'(1);
                  end
                end
              end
              default: begin
                stateNext[i] = StIdle;
                rcNext[i]    = '0;
              end
            endcase
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          outRepeat_tick <= '0;
        end else begin
          outRepeat_tick <= rise | autoNext;
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
          if (reset) begin
            state[i] <= StIdle;
            rc[i]    <= '0;
          end else begin
            state[i] <= stateNext[i];
            rc[i]    <= rcNext[i];
          end
        end
      end
    end else begin : genNoRepeat
      assign outRepeat_tick = outPressed_tick;
    end
  endgenerate

endmodule
